uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  UART receive front end feeding the memory-mapped peripheral block's RXD/CON registers.
//  Oversamples the raw RX pin at 16x, majority-votes each bit and frames 8N1 bytes.
//  Buffers received bytes in a small FIFO and presents the head byte with a valid/pop handshake.
//  Sticky frame-error and overrun flags are cleared by the CPU side.
// PARAMETERS
//  OVS_DIV   325  clk cycles per 16x sample tick (50 MHz / (9600*16)); must be >= 2
//  DEPTH     4    FIFO entries; power of two, >= 2
//  CNT_W     3    width of rx_count; must be log2(DEPTH)+1
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  reset      in   1      synchronous, active-high reset
//  uart_rx    in   1      raw asynchronous RX pin; idle high
//  rx_en      in   1      receive enable; 0 aborts any frame in progress
//  rd_pop     in   1      consume head byte; ignored when rx_valid=0
//  err_clr    in   1      clear frame_err and overrun
//  rx_data    out  8      head byte of FIFO; 8'h00 when empty
//  rx_valid   out  1      FIFO non-empty
//  rx_count   out  CNT_W  number of bytes held, 0..DEPTH
//  frame_err  out  1      sticky: stop bit sampled 0
//  overrun    out  1      sticky: byte completed while FIFO full and no pop
//  busy       out  1      FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM IDLE, synchronizer flops=1, divider and counters 0, FIFO empty.
//   Outputs: rx_data=0, rx_valid=0, rx_count=0, frame_err=0, overrun=0, busy=0.
//  Sync: uart_rx passes through two flops (rx_s). All decisions use rx_s only.
//  Divider: counts 0..OVS_DIV-1; tick=1 for one clk when count==OVS_DIV-1.
//   Divider is held at 0 in IDLE and restarts from 0 on start detect (phase-aligned to edge).
//  Sample index s counts ticks 0..15 within each bit. Bit value = majority of rx_s at s=7,8,9.
//  FSM:
//   IDLE : rx_en=1 and rx_s=0 -> START; s=0.
//   START: at s=9, majority=1 -> IDLE (false start, no flag); else continue. At s=15 -> DATA, bit=0.
//   DATA : at s=9, shift majority into bit[i], LSB first. At s=15: i==7 -> STOP, else i+1.
//   STOP : at s=9 decide, then -> IDLE on the same edge (early resync permitted).
//          majority=1 -> push byte. majority=0 -> discard byte, frame_err<=1.
//   Any state: rx_en=0 -> IDLE next clk; partial byte discarded, no flags. FIFO and flags kept.
//  Latency: rx_valid and rx_count update on the clk edge after the STOP s=9 tick edge.
//  FIFO: rx_data = mem[rd_ptr] (registered storage, combinational head read), 0 when empty.
//   Pointers wrap modulo DEPTH. rx_count is the exact occupancy.
//   Pop alone: count-1. Push alone when not full: count+1.
//   Pop+push same cycle: count unchanged; this includes the full case, which is not an overrun.
//   Push when full without pop: byte dropped, contents unchanged, overrun<=1.
//   Pop when empty: no effect.
//  Flags: err_clr clears both flags. A set event in the same cycle as err_clr wins (flag=1).
//  busy = (state != IDLE).
// TESTING (sim with OVS_DIV=4, DEPTH=4; bit period = 64 clk)
//  1. Send 8N1 0xA5 -> rx_valid=1, rx_data=8'hA5, rx_count=1. rd_pop -> rx_valid=0, rx_data=0.
//  2. Drive a 4-clk low glitch on uart_rx -> FSM returns to IDLE. No push; frame_err=0.
//  3. Send 0x3C with stop bit 0 -> frame_err=1, rx_count=0. err_clr pulse -> frame_err=0.
//  4. Send 0x01..0x05 with no pops -> rx_count=4, overrun=1.
//     Four pops return 01,02,03,04, then rx_valid=0.
//  5. FIFO full; assert rd_pop in the push cycle of a 5th byte 0x77 -> overrun=0, rx_count=4.
//     Drain order is 02,03,04,77.
//  6. Assert reset mid-DATA of 0x5A -> all outputs 0. Next clean frame 0xC3 is received correctly.
//  7. Deassert rx_en mid-frame -> busy=0 next clk, no push, no flags.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling, 3-sample majority vote per bit,
// a small byte FIFO presenting its head with a valid/pop handshake, and
// sticky frame-error / overrun flags cleared from the CPU side.
module uart_rx_fifo #(
   parameter int OVS_DIV = 325,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             uart_rx,
   input  logic             rx_en,
   input  logic             rd_pop,
   input  logic             err_clr,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic [CNT_W-1:0] rx_count,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int DIV_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_next;
   logic             rx_meta, rx_s;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       samp_idx;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             v7, v8;
   logic             tick, maj, start_det;
   logic             push, ferr_set;
   logic [7:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full, pop, do_push, ovr_set;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   assign tick      = (state != IDLE) && (div_cnt == DIV_W'(OVS_DIV - 1));
   assign maj       = majority3(v7, v8, rx_s);
   assign start_det = (state == IDLE) && rx_en && !rx_s;

   // Two-flop synchronizer for the asynchronous RX pin (idle level is high)
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next-state logic; rx_en low forces IDLE from any state
   always_comb begin
      state_next = state;
      if (!rx_en) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (!rx_s) state_next = START;
            START: begin
               if (tick && samp_idx == 4'd9 && maj) state_next = IDLE;
               else if (tick && samp_idx == 4'd15)  state_next = DATA;
            end
            DATA:    if (tick && samp_idx == 4'd15 && bit_idx == 3'd7) state_next = STOP;
            STOP:    if (tick && samp_idx == 4'd9) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // FSM outputs: busy flag and the stop-bit decision (push or frame error)
   always_comb begin
      busy     = (state != IDLE);
      push     = 1'b0;
      ferr_set = 1'b0;
      if (state == STOP && rx_en && tick && samp_idx == 4'd9) begin
         push     = maj;
         ferr_set = !maj;
      end
   end

   // Tick divider and sample/bit counters; held at zero in IDLE and re-phased on start edge
   always_ff @(posedge clk) begin
      if (reset || state_next == IDLE || start_det) begin
         div_cnt  <= '0;
         samp_idx <= 4'd0;
         bit_idx  <= 3'd0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         if (tick) samp_idx <= samp_idx + 4'd1;
         if (tick && state == DATA && samp_idx == 4'd15) bit_idx <= bit_idx + 3'd1;
      end
   end

   // Mid-bit samples for the vote and the LSB-first shift register
   always_ff @(posedge clk) begin
      if (tick && samp_idx == 4'd7) v7 <= rx_s;
      if (tick && samp_idx == 4'd8) v8 <= rx_s;
      if (tick && state == DATA && samp_idx == 4'd9) shift_reg <= {maj, shift_reg[7:1]};
   end

   assign full    = (count == CNT_W'(DEPTH));
   assign pop     = rd_pop && (count != '0);
   assign do_push = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   // FIFO storage; on full with simultaneous pop the write reuses the slot being vacated
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= shift_reg;
   end

   // FIFO pointers and exact occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !do_push) count <= count - CNT_W'(1);
      end
   end

   // Sticky error flags; a set event outranks a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr_set | (frame_err & !err_clr);
         overrun   <= ovr_set  | (overrun   & !err_clr);
      end
   end

   assign rx_data  = (count != '0) ? mem[rd_ptr] : 8'h00;
   assign rx_valid = (count != '0);
   assign rx_count = count;

endmodule
